// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage controller: lw/sw over a req/ack bus, branch resolve,
//             upstream stall and MEM/WB register. Optional access timeout
//             enabled by defining MEM_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_regWrite_ex_mem,
  input  logic        ctrl_memToReg_ex_mem,
  input  logic        ctrl_branch_ex_mem,
  input  logic        ctrl_memRead_ex_mem,
  input  logic        ctrl_memWrite_ex_mem,
  input  logic        zero_ex_mem,
  input  logic [31:0] branch_or_not_address_ex_mem,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] read_data_2_ex_mem,
  input  logic [4:0]  write_register_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_register_mem_wb,
  output logic        misaligned_fault,
  output logic        bus_error
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wb_regwrite;
  logic        r_wb_memtoreg;
  logic [31:0] r_wb_read_data;
  logic [31:0] r_wb_alu_result;
  logic [4:0]  r_wb_write_register;
  logic        r_fault;

  logic        w_op;
  logic        w_mis;
  logic        w_issue;
  logic        w_done;
  logic        w_timeout;
  logic        w_stall;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_bus_error;

  // Limit is hit on the TIMEOUT_CYCLES-th ACCESS cycle still lacking an ack
  assign w_timeout = (r_state == ST_ACCESS) && !dmem_ack && (r_tmo_cnt == c_tmo_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt   <= 8'd0;
      r_bus_error <= 1'b0;
    end else begin
      r_bus_error <= w_timeout;
      if (w_issue) begin
        r_tmo_cnt <= 8'd0;
      end else if ((r_state == ST_ACCESS) && !dmem_ack && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end
    end
  end

  assign bus_error = r_bus_error;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    w_op        = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    w_mis       = w_op && (alu_result_ex_mem[1:0] != 2'b00);
    w_issue     = (r_state == ST_IDLE) && w_op && !w_mis;
    w_done      = (r_state == ST_ACCESS) && dmem_ack;
    w_stall     = w_issue || ((r_state == ST_ACCESS) && !dmem_ack && !w_timeout);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_done || w_timeout) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req               <= 1'b0;
      r_we                <= 1'b0;
      r_addr              <= 32'd0;
      r_wdata             <= 32'd0;
      r_wb_regwrite       <= 1'b0;
      r_wb_memtoreg       <= 1'b0;
      r_wb_read_data      <= 32'd0;
      r_wb_alu_result     <= 32'd0;
      r_wb_write_register <= 5'd0;
      r_fault             <= 1'b0;
    end else begin
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= ctrl_memWrite_ex_mem;
        r_addr  <= alu_result_ex_mem;
        r_wdata <= read_data_2_ex_mem;
      end else if (w_done || w_timeout) begin
        r_req <= 1'b0;
      end

      if (w_done && !r_we) begin
        r_wb_read_data <= dmem_rdata;
      end

      // Stalled edges insert a bubble so each instruction writes back once
      if (w_stall) begin
        r_wb_regwrite <= 1'b0;
      end else begin
        r_wb_regwrite       <= ctrl_regWrite_ex_mem && !w_mis && !w_timeout;
        r_wb_memtoreg       <= ctrl_memToReg_ex_mem;
        r_wb_alu_result     <= alu_result_ex_mem;
        r_wb_write_register <= write_register_ex_mem;
      end

      r_fault <= w_mis && (r_state == ST_IDLE);
    end
  end

  assign dmem_req              = r_req;
  assign dmem_we               = r_we;
  assign dmem_addr             = r_addr;
  assign dmem_wdata            = r_wdata;
  assign stall                 = w_stall;
  assign pc_src                = ctrl_branch_ex_mem && zero_ex_mem && !w_stall;
  assign branch_target         = branch_or_not_address_ex_mem;
  assign ctrl_regWrite_mem_wb  = r_wb_regwrite;
  assign ctrl_memToReg_mem_wb  = r_wb_memtoreg;
  assign read_data_mem_wb      = r_wb_read_data;
  assign alu_result_mem_wb     = r_wb_alu_result;
  assign write_register_mem_wb = r_wb_write_register;
  assign misaligned_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench: directed table, reset/timeout sequences
//             and random instructions against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int c_tmo = 4;
`else
  localparam int c_tmo = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rw_i, m2r_i, br_i, rd_i, wr_i, zero_i;
  logic [31:0] target_i, alu_i, wdata_i;
  logic [4:0]  wreg_i;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pc_src;
  logic [31:0] branch_target;
  logic        wb_rw, wb_m2r;
  logic [31:0] wb_rd, wb_alu;
  logic [4:0]  wb_wreg;
  logic        misaligned_fault, bus_error;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(c_tmo)) dut (
    .clk(clk), .reset(reset),
    .ctrl_regWrite_ex_mem(rw_i), .ctrl_memToReg_ex_mem(m2r_i),
    .ctrl_branch_ex_mem(br_i), .ctrl_memRead_ex_mem(rd_i),
    .ctrl_memWrite_ex_mem(wr_i), .zero_ex_mem(zero_i),
    .branch_or_not_address_ex_mem(target_i), .alu_result_ex_mem(alu_i),
    .read_data_2_ex_mem(wdata_i), .write_register_ex_mem(wreg_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .ctrl_regWrite_mem_wb(wb_rw), .ctrl_memToReg_mem_wb(wb_m2r),
    .read_data_mem_wb(wb_rd), .alu_result_mem_wb(wb_alu),
    .write_register_mem_wb(wb_wreg),
    .misaligned_fault(misaligned_fault), .bus_error(bus_error)
  );

  typedef struct {
    logic        rd, wr, br, zero, rw, m2r;
    logic [31:0] addr, wdata, target, rdata;
    logic [4:0]  wreg;
    int          lat;
    logic        e_req, e_we, e_fault, e_pc, e_wbrw;
    int          e_stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, br, zero, rw, m2r,
                              input logic [31:0] addr, wdata, target, rdata,
                              input logic [4:0] wreg, input int lat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.br = br; v.zero = zero; v.rw = rw; v.m2r = m2r;
    v.addr = addr; v.wdata = wdata; v.target = target; v.rdata = rdata;
    v.wreg = wreg; v.lat = lat;
    v.e_req = 0; v.e_we = 0; v.e_fault = 0; v.e_pc = 0; v.e_wbrw = 0; v.e_stall = 0;
    return v;
  endfunction

  function automatic vec_t expect_(input vec_t v, input logic req, we, fault, pc, wbrw,
                                   input int st);
    v.e_req = req; v.e_we = we; v.e_fault = fault; v.e_pc = pc; v.e_wbrw = wbrw;
    v.e_stall = st;
    return v;
  endfunction

  // Reference: an aligned memory op costs the issue cycle plus every wait cycle
  function automatic vec_t model(input vec_t v);
    logic mem, mis;
    mem = v.rd | v.wr;
    mis = mem && (v.addr % 4 != 0);
    v.e_req   = mem && !mis;
    v.e_we    = v.wr;
    v.e_fault = mis;
    v.e_stall = v.e_req ? v.lat + 1 : 0;
    v.e_pc    = v.br && v.zero && (v.e_stall == 0);
    v.e_wbrw  = v.rw && !mis;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rd_i = v.rd; wr_i = v.wr; br_i = v.br; zero_i = v.zero; rw_i = v.rw; m2r_i = v.m2r;
    alu_i = v.addr; wdata_i = v.wdata; target_i = v.target; wreg_i = v.wreg;
  endtask

  task automatic do_vec(input vec_t v);
    int   acc, stalls;
    logic s;
    bit   done;
    @(negedge clk);
    drive(v);
    dmem_ack   = v.e_req ? 1'b0 : 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    acc = -1; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        dmem_ack = 1'b0;
      end
      if (acc == v.lat) begin
        dmem_ack   = 1'b1;
        dmem_rdata = v.rdata;
      end
      #1;
      s = stall;
      if (cyc == 0) begin
        chk("stall_first", stall, v.e_stall != 0);
        chk("pc_src", pc_src, v.e_pc);
        chk("branch_target", branch_target, v.target);
      end
      if (s) stalls++;
      @(posedge clk);
      #1;
      if (s) begin
        chk("wb_bubble", wb_rw, 0);
        chk("req_held", dmem_req, 1);
        chk("we", dmem_we, v.e_we);
        chk("addr", dmem_addr, v.addr);
        chk("wdata", dmem_wdata, v.wdata);
        chk("fault_idle", misaligned_fault, 0);
        acc = (acc < 0) ? 0 : acc + 1;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL stall_bound: stall still high after 40 cycles");
    end
    if (v.e_req && !v.e_we) exp_rd = v.rdata;
    chk("req_dropped", dmem_req, 0);
    chk("stall_cycles", stalls, v.e_stall);
    chk("fault", misaligned_fault, v.e_fault);
    chk("bus_error", bus_error, 0);
    chk("wb_regwrite", wb_rw, v.e_wbrw);
    chk("wb_memtoreg", wb_m2r, v.m2r);
    chk("wb_alu", wb_alu, v.addr);
    chk("wb_wreg", wb_wreg, v.wreg);
    chk("wb_rdata", wb_rd, exp_rd);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0; exp_rd = 32'd0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we_addr", {31'd0, dmem_we} | dmem_addr | dmem_wdata, 0);
    chk("rst_wb", {wb_rw, wb_m2r, wb_wreg} | wb_rd | wb_alu, 0);
    chk("rst_flags", {misaligned_fault, bus_error, stall}, 0);
    @(negedge clk); reset = 1'b0;

    //                rd wr br z rw m2r addr          wdata         target        rdata         wreg lat
    tbl.push_back(expect_(mk(1, 0, 0, 0, 1, 1, 32'h0000_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd3, 3), 1, 0, 0, 0, 1, 4));
    tbl.push_back(expect_(mk(0, 1, 0, 0, 0, 0, 32'h0000_0020, 32'h1234_5678, 32'h0, 32'h5555_5555, 5'd0, 0), 1, 1, 0, 0, 0, 1));
    tbl.push_back(expect_(mk(1, 0, 0, 0, 1, 1, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 5'd7, 0), 0, 0, 1, 0, 0, 0));
    tbl.push_back(expect_(mk(0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 32'h0040_0100, 32'h0, 5'd0, 0), 0, 0, 0, 1, 0, 0));
    tbl.push_back(expect_(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0040_0100, 32'h0, 5'd0, 0), 0, 0, 0, 0, 0, 0));
    tbl.push_back(expect_(mk(0, 0, 0, 0, 1, 0, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0, 5'd9, 0), 0, 0, 0, 0, 1, 0));
    tbl.push_back(expect_(mk(1, 1, 0, 0, 0, 0, 32'h0000_0044, 32'hA5A5_0F0F, 32'h0, 32'h1111_2222, 5'd2, 2), 1, 1, 0, 0, 0, 3));
    tbl.push_back(expect_(mk(0, 1, 0, 0, 0, 0, 32'h0000_0022, 32'h0, 32'h0, 32'h0, 5'd0, 0), 0, 1, 1, 0, 0, 0));
    tbl.push_back(expect_(mk(1, 0, 0, 0, 1, 1, 32'h0000_0080, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd31, 1), 1, 0, 0, 0, 1, 2));
`ifndef MEM_TIMEOUT_EN
    tbl.push_back(expect_(mk(1, 0, 0, 0, 1, 1, 32'h0000_0100, 32'h0, 32'h0, 32'h7777_8888, 5'd4, 20), 1, 0, 0, 0, 1, 21));
`endif
    foreach (tbl[i]) do_vec(tbl[i]);

    // Reset during the second ACCESS cycle; EX/MEM is cleared alongside
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 1, 1, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 5'd5, 0));
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("rst_seq_req", dmem_req, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("rst_mid_req", dmem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_wb", {wb_rw, wb_m2r, wb_wreg} | wb_rd | wb_alu, 0);
    @(negedge clk); reset = 1'b0; exp_rd = 32'd0;

`ifdef MEM_TIMEOUT_EN
    begin
      int stalls;
      logic s;
      @(negedge clk);
      drive(mk(1, 0, 0, 0, 1, 1, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 5'd6, 0));
      dmem_ack = 1'b0; stalls = 0; s = 1'b1;
      for (int cyc = 0; cyc < 40 && s; cyc++) begin
        if (cyc > 0) @(negedge clk);
        #1; s = stall;
        if (s) stalls++;
        @(posedge clk); #1;
        if (s) chk("tmo_no_error_yet", bus_error, 0);
      end
      chk("tmo_stall_cycles", stalls, c_tmo);
      chk("tmo_bus_error", bus_error, 1);
      chk("tmo_req", dmem_req, 0);
      chk("tmo_wb_rw", wb_rw, 0);
      chk("tmo_wb_rd", wb_rd, exp_rd);
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      chk("tmo_pulse_end", bus_error, 0);
    end
`endif

    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 5);
      a = $urandom;
      rv = mk(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
      case (kind)
        0: begin rv.rd = 1; rv.addr[1:0] = 2'b00; rv.br = 0; end
        1: begin rv.wr = 1; rv.addr[1:0] = 2'b00; rv.br = 0; end
        2: begin rv.rd = 1; rv.wr = 1; rv.addr[1:0] = 2'b00; rv.br = 0; end
        3: begin rv.rd = 1; rv.addr[1:0] = 2'($urandom_range(1, 3)); end
        default: ;
      endcase
      do_vec(model(rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller on the consumer side of the EX/MEM pipeline register.
- Takes the EX/MEM control and data outputs and drives a request/acknowledge data-memory bus for lw/sw.
- Resolves branches, stalls the upstream pipeline while an access is outstanding, and owns the MEM/WB pipeline register.

Parameters:
- TIMEOUT_CYCLES, 16: ACCESS cycles without dmem_ack before abort; used only with MEM_TIMEOUT_EN.

Ports:
- Clock and reset (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem, ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, zero_ex_mem  in  1 each  EX/MEM control and zero flag
- branch_or_not_address_ex_mem, alu_result_ex_mem, read_data_2_ex_mem  in  32 each  branch target, address/ALU result, store data
- write_register_ex_mem  in  5  destination register
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  word address, registered
- dmem_wdata  out  32  store data, registered
- dmem_rdata  in  32  load data, valid when dmem_ack = 1
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- pc_src  out  1  take branch
- branch_target  out  32  next PC when pc_src = 1
- ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb  out  1 each  MEM/WB control
- read_data_mem_wb, alu_result_mem_wb  out  32 each  MEM/WB data
- write_register_mem_wb  out  5  MEM/WB destination
- misaligned_fault  out  1  one-cycle pulse
- bus_error  out  1  one-cycle pulse (timeout)

Behaviour:
- Reset: all registered outputs are 0 at the first clk edge with reset = 1 (dmem_*, MEM/WB fields, misaligned_fault, bus_error). State goes to IDLE and the timeout counter is cleared. Reset mid-ACCESS abandons the access; dmem_req is 0 on the following cycle.
- Decode:
  - op = (ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem).
  - mis = op & (alu_result_ex_mem[1:0] != 0).
  - If both read and write are 1, the access is a write.
- States: IDLE and ACCESS.
- IDLE:
  - If op & ~mis: next edge sets dmem_req = 1, dmem_we = ctrl_memWrite_ex_mem, dmem_addr = alu_result_ex_mem, dmem_wdata = read_data_2_ex_mem, and goes to ACCESS.
  - dmem_ack while in IDLE is ignored.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - On dmem_ack: next edge clears dmem_req, captures dmem_rdata into read_data_mem_wb (reads only; writes leave it unchanged) and returns to IDLE.
- stall (combinational) = (IDLE & op & ~mis) | (ACCESS & ~dmem_ack).
  - A zero-wait ack (ack in the first ACCESS cycle) gives exactly 1 stall cycle.
- MEM/WB loading:
  - On every edge where stall = 0, ctrl_regWrite, ctrl_memToReg, alu_result and write_register are loaded from EX/MEM.
  - On edges where stall = 1, a bubble is loaded: ctrl_regWrite_mem_wb = 0, other fields unchanged.
  - This guarantees one writeback per instruction.
- Misaligned access:
  - No bus request and no stall.
  - misaligned_fault = 1 for exactly the next cycle.
  - MEM/WB loads with ctrl_regWrite_mem_wb forced to 0.
- Branch (combinational): pc_src = ctrl_branch_ex_mem & zero_ex_mem & ~stall; branch_target = branch_or_not_address_ex_mem.
- One access outstanding at a time. No new request is issued on the edge that completes an access, because EX/MEM advances on that edge.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: dmem_req drops, state returns to IDLE, bus_error pulses 1 cycle, stall drops that cycle, and MEM/WB loads a bubble with regWrite = 0.
  - An ack in the same cycle as the limit wins; there is no error.
- Not defined: no counter; bus_error is tied to 0; ACCESS waits indefinitely.

Test Plan:
- lw, addr 0x0000_0010, ack 3 cycles after req, rdata 0xDEAD_BEEF -> stall high 4 cycles; then read_data_mem_wb = 0xDEADBEEF, ctrl_memToReg_mem_wb = 1, exactly one cycle with ctrl_regWrite_mem_wb = 1.
- sw, addr 0x20, data 0x1234_5678, ack in first ACCESS cycle -> dmem_we = 1, dmem_addr = 0x20, dmem_wdata = 0x12345678; stall 1 cycle; ctrl_regWrite_mem_wb = 0.
- lw, addr 0x0000_0013 -> dmem_req stays 0, stall = 0, misaligned_fault pulses 1 cycle, ctrl_regWrite_mem_wb = 0.
- beq, zero = 1, target 0x0040_0100 -> pc_src = 1 and branch_target = 0x00400100 the same cycle; zero = 0 -> pc_src = 0.
- reset asserted on the 2nd ACCESS cycle, ack never sent -> next cycle dmem_req = 0, stall = 0, all MEM/WB outputs 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, lw with no ack -> bus_error pulses after 4 ACCESS cycles, dmem_req = 0, ctrl_regWrite_mem_wb = 0.
